dmem_access_unit: RTL and testbench

MEM-stage data-memory access unit for the 5-stage RISC-V core. It takes the memory controls produced by the control unit: `mem_do_read_ctrl`, `mem_do_write_ctrl` and `mem_ctrl`. It also takes the ALU-computed address and the store data. From these it runs a valid/ready request plus response transaction to the data memory, stalling the pipeline until the access retires. It is the consuming end of the control unit's memory-control interface, and it supports LW and SW.

---
 rtl/dmem_access_unit_pkg.sv | 23 ++
 rtl/dmem_access_unit_if.sv | 34 +++
 rtl/dmem_access_unit.sv | 123 ++++++++++++
 tb/tb_dmem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the MEM-stage data-memory access unit: the control unit's
// memory-operation encoding and the access FSM state encoding.
package dmem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_NOP = 2'd0,
        MEM_LW  = 2'd1,
        MEM_SW  = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } dmem_state_t;

    // A word access is legal only when the two byte-offset bits are zero.
    function automatic logic is_word_aligned(input logic [1:0] byte_off);
        return (byte_off == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Valid/ready request plus valid-only response bus between the access unit
// (master) and the data memory (slave).
interface dmem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: turns LW/SW controls into one bus
// transaction per instruction and stalls the pipeline until it retires.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_do_read_ctrl,
    input  logic                 mem_do_write_ctrl,
    input  mem_op_t              mem_ctrl,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [DATA_W-1:0]    wdata_in,
    output logic                 stall_out,
    output logic [DATA_W-1:0]    rdata_out,
    output logic                 ld_done,
    output logic                 misalign_fault,
    dmem_access_unit_if.master   bus
);

    dmem_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              write_reg, write_next;
    logic              fault_reg, fault_next;

    logic launch_ld;
    logic launch_st;
    logic launch;
    logic aligned;

    // Store wins when both flags claim a launch.
    assign launch_st = mem_do_write_ctrl && (mem_ctrl == MEM_SW);
    assign launch_ld = !launch_st && mem_do_read_ctrl && (mem_ctrl == MEM_LW);
    assign launch    = launch_st || launch_ld;
    assign aligned   = is_word_aligned(addr_in[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            write_reg <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            write_reg <= write_next;
            fault_reg <= fault_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        write_next = write_reg;
        fault_next = fault_reg;
        unique case (state_reg)
            IDLE: begin
                if (launch) begin
                    write_next = launch_st;
                    fault_next = !aligned;
                    if (aligned) begin
                        addr_next  = {addr_in[ADDR_W-1:2], 2'b00};
                        wdata_next = wdata_in;
                        state_next = REQ;
                    end else begin
                        // A dropped load still retires, with a zero result.
                        if (launch_ld) begin
                            rdata_next = '0;
                        end
                        state_next = DONE;
                    end
                end
            end
            REQ: begin
                if (bus.req_ready) begin
                    state_next = write_reg ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus.rsp_valid) begin
                    rdata_next = bus.rsp_rdata;
                    state_next = DONE;
                end
            end
            DONE: begin
                // The instruction advances this cycle; never relaunch it.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_valid = (state_reg == REQ);
    assign bus.req_write = write_reg;
    assign bus.req_addr  = addr_reg;
    assign bus.req_wdata = wdata_reg;

    assign rdata_out      = rdata_reg;
    assign ld_done        = (state_reg == DONE) && !write_reg;
    assign misalign_fault = (state_reg == DONE) && fault_reg;

    // Gated by rst so the pipeline is released while the unit is held in reset.
    assign stall_out = !rst && (((state_reg == IDLE) && launch) ||
                                (state_reg == REQ) || (state_reg == WAIT_RSP));

    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.req_valid && !bus.req_ready) |=>
            ($stable(bus.req_addr) && $stable(bus.req_wdata) && $stable(bus.req_write)));

    a_pulse_in_done: assert property (@(posedge clk) disable iff (rst)
        (ld_done || misalign_fault) |-> (state_reg == DONE));

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed table, randomized traffic
// against a transaction-level model, and a reset-during-WAIT_RSP sequence.
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_do_read_ctrl;
    logic        mem_do_write_ctrl;
    mem_op_t     mem_ctrl;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        stall_out;
    logic [31:0] rdata_out;
    logic        ld_done;
    logic        misalign_fault;

    dmem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_do_read_ctrl  (mem_do_read_ctrl),
        .mem_do_write_ctrl (mem_do_write_ctrl),
        .mem_ctrl          (mem_ctrl),
        .addr_in           (addr_in),
        .wdata_in          (wdata_in),
        .stall_out         (stall_out),
        .rdata_out         (rdata_out),
        .ld_done           (ld_done),
        .misalign_fault    (misalign_fault),
        .bus               (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // bus_mem is the memory seen through the bus; ref_mem/ref_rdata are the model.
    logic [31:0] bus_mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ref_rdata;

    typedef struct {
        logic        rd;
        logic        wr;
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rwait;
        int          rspw;
        bit          stray;
        int          e_stall;
        int          e_req;
        logic        e_write;
        int          e_ld;
        int          e_fault;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Transaction-level model: what one instruction should do, from the rules alone.
    task automatic model(input vec_t v, output vec_t e);
        bit is_st, is_ld, launch, mis;
        e = v;
        is_st  = v.wr && (v.op == MEM_SW);
        is_ld  = !is_st && v.rd && (v.op == MEM_LW);
        launch = is_st || is_ld;
        mis    = launch && (v.addr[1:0] != 2'b00);
        if (!launch)    e.e_stall = 0;
        else if (mis)   e.e_stall = 1;
        else if (is_st) e.e_stall = 2 + v.rwait;
        else            e.e_stall = 2 + v.rwait + v.rspw;
        e.e_req   = (launch && !mis) ? 1 : 0;
        e.e_write = is_st;
        e.e_ld    = is_ld ? 1 : 0;
        e.e_fault = mis ? 1 : 0;
        if (is_ld) ref_rdata = mis ? 32'h0 : ref_mem[v.addr[9:2]];
        if (is_st && !mis) ref_mem[v.addr[9:2]] = v.wdata;
        e.e_rdata = ref_rdata;
    endtask

    // Presents one instruction and acts as the memory until the pipeline is released.
    task automatic run_txn(input int id, input vec_t v);
        int          stall_cnt = 0, req_cnt = 0, ld_cnt = 0, flt_cnt = 0;
        int          wait_seen = 0, since_hs = -1, cyc = 0;
        bit          done = 0, unstable = 0, prev_hold = 0;
        logic [31:0] hs_addr = 0, hs_wdata = 0, p_addr = 0, p_wdata = 0, rsp_word = 0;
        logic        hs_write = 0, p_write = 0, last_ld = 0, last_flt = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            mem_do_read_ctrl  = v.rd;
            mem_do_write_ctrl = v.wr;
            mem_ctrl          = v.op;
            addr_in           = v.addr;
            wdata_in          = v.wdata;
            bus.req_ready = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.rsp_rdata = 32'h0;
            if (since_hs >= 0) begin
                since_hs++;
                if (since_hs == v.rspw) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = rsp_word;
                end
            end
            if (bus.req_valid) begin
                if (prev_hold && (bus.req_addr !== p_addr || bus.req_wdata !== p_wdata ||
                                  bus.req_write !== p_write)) unstable = 1;
                if (wait_seen >= v.rwait) bus.req_ready = 1'b1;
                else wait_seen++;
                if (v.stray) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = 32'hBAD0BAD0;
                end
            end
            #1;
            if (stall_out) stall_cnt++;
            else done = 1;
            if (ld_done) ld_cnt++;
            if (misalign_fault) flt_cnt++;
            last_ld  = ld_done;
            last_flt = misalign_fault;
            if (bus.req_valid && bus.req_ready) begin
                req_cnt++;
                hs_addr  = bus.req_addr;
                hs_wdata = bus.req_wdata;
                hs_write = bus.req_write;
                if (bus.req_write) bus_mem[bus.req_addr[9:2]] = bus.req_wdata;
                else begin
                    rsp_word = bus_mem[bus.req_addr[9:2]];
                    since_hs = 0;
                end
            end
            prev_hold = bus.req_valid && !bus.req_ready;
            p_addr    = bus.req_addr;
            p_wdata   = bus.req_wdata;
            p_write   = bus.req_write;
            cyc++;
        end
        $display("[TB] txn %0d rd=%0d wr=%0d op=%0d addr=%08h stall=%0d reqs=%0d ld=%0d fault=%0d rdata=%08h",
                 id, v.rd, v.wr, v.op, v.addr, stall_cnt, req_cnt, ld_cnt, flt_cnt, rdata_out);
        check("released", 32'(done), 32'd1);
        check("stall_cycles", stall_cnt, v.e_stall);
        check("req_count", req_cnt, v.e_req);
        check("ld_done_count", ld_cnt, v.e_ld);
        check("ld_done_at_release", 32'(last_ld), 32'(v.e_ld));
        check("fault_count", flt_cnt, v.e_fault);
        check("fault_at_release", 32'(last_flt), 32'(v.e_fault));
        check("rdata_out", rdata_out, v.e_rdata);
        check("req_stable", 32'(unstable), 32'd0);
        if (v.e_req != 0) begin
            check("req_addr", hs_addr, {v.addr[31:2], 2'b00});
            check("req_write", 32'(hs_write), 32'(v.e_write));
            if (v.e_write) check("req_wdata", hs_wdata, v.wdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        vec_t rv;
        rst = 1'b1;
        mem_do_read_ctrl = 1'b0;
        mem_do_write_ctrl = 1'b0;
        mem_ctrl = MEM_NOP;
        addr_in = 32'h0;
        wdata_in = 32'h0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 32'h5A5A0000 ^ (i * 32'h01010101);
            ref_mem[i] = bus_mem[i];
        end
        bus_mem[32'h204 >> 2] = 32'h12345678;
        ref_mem[32'h204 >> 2] = 32'h12345678;
        ref_rdata = 32'h0;

        //        rd    wr    op      addr        wdata         rw rsp stray stall req wr    ld flt rdata
        vecs[0]  = '{1'b0, 1'b1, MEM_SW,  32'h100, 32'hDEADBEEF, 0, 1, 0, 2, 1, 1'b1, 0, 0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, MEM_LW,  32'h204, 32'h0,        2, 3, 0, 7, 1, 1'b0, 1, 0, 32'h12345678};
        vecs[2]  = '{1'b1, 1'b0, MEM_LW,  32'h102, 32'h0,        0, 1, 0, 1, 0, 1'b0, 1, 1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, MEM_NOP, 32'h100, 32'h0,        0, 1, 0, 0, 0, 1'b0, 0, 0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, MEM_NOP, 32'h3C,  32'h1,        0, 1, 0, 0, 0, 1'b0, 0, 0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, MEM_SW,  32'h104, 32'hA5A5A5A5, 0, 1, 0, 2, 1, 1'b1, 0, 0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, MEM_SW,  32'h0,   32'hCAFEF00D, 0, 1, 0, 2, 1, 1'b1, 0, 0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, MEM_LW,  32'h0,   32'h0,        1, 1, 1, 4, 1, 1'b0, 1, 0, 32'hCAFEF00D};
        vecs[8]  = '{1'b0, 1'b1, MEM_LW,  32'h8,   32'h77,       0, 1, 0, 0, 0, 1'b0, 0, 0, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 1'b0, MEM_SW,  32'h8,   32'h77,       0, 1, 0, 0, 0, 1'b0, 0, 0, 32'hCAFEF00D};
        vecs[10] = '{1'b0, 1'b1, MEM_SW,  32'h1,   32'h99,       0, 1, 0, 1, 0, 1'b1, 0, 1, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 1'b0, MEM_LW,  32'h100, 32'h0,        0, 1, 0, 3, 1, 1'b0, 1, 0, 32'hDEADBEEF};

        repeat (3) @(negedge clk);
        #1;
        check("reset_req_valid", 32'(bus.req_valid), 32'd0);
        check("reset_stall", 32'(stall_out), 32'd0);
        check("reset_ld_done", 32'(ld_done), 32'd0);
        check("reset_fault", 32'(misalign_fault), 32'd0);
        check("reset_rdata", rdata_out, 32'd0);
        check("reset_req_addr", bus.req_addr, 32'd0);
        check("reset_req_wdata", bus.req_wdata, 32'd0);
        check("reset_req_write", 32'(bus.req_write), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; the model runs alongside only to keep its memory in step.
        for (int i = 0; i < 12; i++) begin
            model(vecs[i], e);
            run_txn(i, vecs[i]);
        end

        for (int i = 0; i < 120; i++) begin
            rv.rd    = 1'($urandom_range(0, 1));
            rv.wr    = 1'($urandom_range(0, 1));
            rv.op    = mem_op_t'($urandom_range(0, 2));
            rv.addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 5) == 0) rv.addr[1:0] = 2'($urandom_range(1, 3));
            rv.wdata = $urandom;
            rv.rwait = $urandom_range(0, 3);
            rv.rspw  = $urandom_range(1, 3);
            rv.stray = ($urandom_range(0, 3) == 0);
            model(rv, e);
            run_txn(100 + i, e);
        end

        // Reset while a load waits for its response.
        @(negedge clk);
        mem_do_read_ctrl  = 1'b1;
        mem_do_write_ctrl = 1'b0;
        mem_ctrl          = MEM_LW;
        addr_in           = 32'h8;
        bus.req_ready     = 1'b1;
        bus.rsp_valid     = 1'b0;
        @(negedge clk);
        #1;
        check("rst_seq_req_valid", 32'(bus.req_valid), 32'd1);
        @(negedge clk);
        #1;
        check("rst_seq_in_wait", {31'h0, bus.req_valid, stall_out}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_async_stall", 32'(stall_out), 32'd0);
        check("rst_async_ld_done", 32'(ld_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_do_read_ctrl = 1'b0;
        mem_ctrl         = MEM_NOP;
        bus.req_ready    = 1'b0;
        bus.rsp_valid    = 1'b1;
        bus.rsp_rdata    = 32'hFEEDFACE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("late_rsp_ld_done", 32'(ld_done), 32'd0);
            check("late_rsp_stall", 32'(stall_out), 32'd0);
            check("late_rsp_req_valid", 32'(bus.req_valid), 32'd0);
        end
        check("late_rsp_rdata", rdata_out, 32'd0);
        bus.rsp_valid = 1'b0;
        ref_rdata = 32'h0;

        // Recovery after reset: one ordinary load.
        rv = '{1'b1, 1'b0, MEM_LW, 32'h100, 32'h0, 1, 2, 0, 0, 0, 1'b0, 0, 0, 32'h0};
        model(rv, e);
        run_txn(999, e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
